pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed ID/EX latch, instantiated between any two adjacent pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of configurable width plus a valid bit.
- Decodes the global stall vector at a configurable stage index to hold or insert bubbles.
- Handles flushes from several sources.
- Tracks deferred kills of up to KILL_DEPTH wrong-path entries still held upstream when a flush lands during a stall.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 19 +
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall encodings, stage indices and per-stage NOP payloads.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int PIPE_STALL_W = 6;

    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    // Payload each stage register loads when it carries no instruction.
    localparam logic [31:0] NOP_ID_EX  = 32'h0000_0013;
    localparam logic [31:0] NOP_EX_MEM = 32'h0000_0000;
    localparam logic [31:0] NOP_MEM_WB = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones until reset.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall decode, multi-source flush and deferred kills.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  NOP_DATA   = '0,
    parameter int                 STALL_W    = PIPE_STALL_W,
    parameter int                 STAGE      = STAGE_ID,
    parameter int                 NFLUSH     = 1,
    parameter int                 KILL_DEPTH = 1,
    parameter int                 CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    input  logic [STALL_W-1:0]              stall,
    input  logic [NFLUSH-1:0]               flush,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    output logic [$clog2(KILL_DEPTH+1)-1:0] kill_pending
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]                bubble_count,
    output logic [CNT_W-1:0]                kill_count
`endif
);

    localparam int KPW = $clog2(KILL_DEPTH + 1);

    if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE out of range");
    end
    if (KILL_DEPTH < 1) begin : g_bad_kill_depth
        $error("pipe_stage_reg: KILL_DEPTH must be at least 1");
    end

    logic fl, up, dn;
    logic is_bubble, is_advance, kill_live;
    logic unused_stall;

    assign fl           = |flush;
    assign up           = (stall[STAGE]   == STOP);
    assign dn           = (stall[STAGE+1] == STOP);
    assign is_bubble    = !fl && up && !dn;
    assign is_advance   = !fl && !up;
    assign kill_live    = (kill_pending != '0);
    // Only two bits of the global vector matter to this stage.
    assign unused_stall = ^stall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data     <= NOP_DATA;
            out_valid    <= 1'b0;
            kill_pending <= '0;
        end else if (fl) begin
            out_data     <= NOP_DATA;
            out_valid    <= 1'b0;
            kill_pending <= up ? KPW'(KILL_DEPTH) : '0;
        end else if (is_bubble) begin
            out_data  <= NOP_DATA;
            out_valid <= 1'b0;
        end else if (is_advance) begin
            if (kill_live) begin
                out_data  <= NOP_DATA;
                out_valid <= 1'b0;
                // Invalid entries are not wrong-path instructions, so they keep the budget.
                if (in_valid) begin
                    kill_pending <= kill_pending - KPW'(1);
                end
            end else begin
                out_data  <= in_data;
                out_valid <= in_valid;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic kill_inc;

    assign kill_inc = (fl && out_valid) || (is_advance && kill_live && in_valid);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (is_bubble),
        .count (bubble_count)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (kill_inc),
        .count (kill_count)
    );
`else
    // Counters are compiled out; the functional path above is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg with KILL_DEPTH=2 and two flush sources.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic [5:0]  stall;
    logic [1:0]  flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  kill_pending;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]  bubble_count;
    logic [3:0]  kill_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_stage_reg #(
        .DATA_W     (32),
        .NOP_DATA   (NOP),
        .STALL_W    (6),
        .STAGE      (2),
        .NFLUSH     (2),
        .KILL_DEPTH (2),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .kill_pending (kill_pending)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .bubble_count (bubble_count),
        .kill_count   (kill_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        v;
        logic [5:0]  st;
        logic [1:0]  fl;
        logic [31:0] ed;
        logic        ev;
        logic [1:0]  ek;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] d, logic v, logic [5:0] st, logic [1:0] fl,
                                logic [31:0] ed, logic ev, logic [1:0] ek);
        vec_t r;
        r.d = d; r.v = v; r.st = st; r.fl = fl;
        r.ed = ed; r.ev = ev; r.ek = ek;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic [5:0] st, input logic [1:0] fl);
        in_data  = d;
        in_valid = v;
        stall    = st;
        flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0, 1'b0, 6'b0, 2'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Sequential table: each row is one edge; expectations assume the rows before it.
        vecs.push_back(mk(32'h1234_5678, 1, 6'b000000, 2'b00, 32'h1234_5678, 1, 0)); // advance
        vecs.push_back(mk(32'h0000_00AA, 0, 6'b000000, 2'b00, 32'h0000_00AA, 0, 0)); // advance, invalid keeps data
        vecs.push_back(mk(32'hCAFE_0001, 1, 6'b000000, 2'b00, 32'hCAFE_0001, 1, 0));
        vecs.push_back(mk(32'h0000_0011, 1, 6'b000100, 2'b00, NOP,           0, 0)); // bubble
        vecs.push_back(mk(32'h0000_0022, 1, 6'b000000, 2'b00, 32'h0000_0022, 1, 0));
        vecs.push_back(mk(32'h0000_0033, 1, 6'b001100, 2'b00, 32'h0000_0022, 1, 0)); // hold x3
        vecs.push_back(mk(32'h0000_0033, 1, 6'b001100, 2'b00, 32'h0000_0022, 1, 0));
        vecs.push_back(mk(32'h0000_0033, 1, 6'b001100, 2'b00, 32'h0000_0022, 1, 0));
        vecs.push_back(mk(32'h0000_0044, 1, 6'b001000, 2'b00, 32'h0000_0044, 1, 0)); // only dn stalled: advance
        vecs.push_back(mk(32'h0000_0055, 1, 6'b000100, 2'b01, NOP,           0, 2)); // flush while up stalled
        vecs.push_back(mk(32'h0000_0055, 1, 6'b001100, 2'b10, NOP,           0, 2)); // flush beats hold, no accumulate
        vecs.push_back(mk(32'h0000_000A, 1, 6'b000000, 2'b00, NOP,           0, 1)); // kill
        vecs.push_back(mk(32'h0000_00B0, 0, 6'b000000, 2'b00, NOP,           0, 1)); // invalid: no decrement
        vecs.push_back(mk(32'h0000_0066, 1, 6'b000100, 2'b00, NOP,           0, 1)); // bubble keeps kills
        vecs.push_back(mk(32'h0000_0066, 1, 6'b001100, 2'b00, NOP,           0, 1)); // hold keeps kills
        vecs.push_back(mk(32'h0000_0077, 1, 6'b000100, 2'b01, NOP,           0, 2)); // stalled flush replaces count
        vecs.push_back(mk(32'h0000_000A, 1, 6'b000000, 2'b00, NOP,           0, 1)); // A killed
        vecs.push_back(mk(32'h0000_00B1, 0, 6'b000000, 2'b00, NOP,           0, 1)); // invalid entry
        vecs.push_back(mk(32'h0000_000B, 1, 6'b000000, 2'b00, NOP,           0, 0)); // B killed
        vecs.push_back(mk(32'h0000_000C, 1, 6'b000000, 2'b00, 32'h0000_000C, 1, 0)); // C passes
        vecs.push_back(mk(32'h0000_000D, 1, 6'b000000, 2'b01, NOP,           0, 0)); // flush, no stall
        vecs.push_back(mk(32'h0000_000E, 1, 6'b000000, 2'b00, 32'h0000_000E, 1, 0));
        vecs.push_back(mk(32'h0000_0088, 1, 6'b001000, 2'b10, NOP,           0, 0)); // flush with dn stall only
        vecs.push_back(mk(32'h0000_000F, 1, 6'b000000, 2'b00, 32'h0000_000F, 1, 0));

        rst = 1'b0;
        drive(32'h0, 1'b0, 6'b0, 2'b0);
        #12;
        check("reset_data",  out_data, NOP);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_kill",  32'(kill_pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].st, vecs[i].fl);
            step();
            check($sformatf("vec%0d_data", i),  out_data, vecs[i].ed);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_kill", i),  32'(kill_pending), 32'(vecs[i].ek));
        end

        // Asynchronous reset between edges while a valid instruction is held.
        drive(32'hDEAD_BEEF, 1'b1, 6'b0, 2'b0);
        step();
        check("pre_areset_data", out_data, 32'hDEAD_BEEF);
        #2 rst = 1'b0;
        #1;
        check("areset_data",  out_data, NOP);
        check("areset_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset clears a pending kill count.
        drive(32'h0000_0001, 1'b1, 6'b000100, 2'b01);
        step();
        check("pre_areset_kill", 32'(kill_pending), 32'd2);
        drive(32'h0000_0001, 1'b1, 6'b000100, 2'b00);
        #2 rst = 1'b0;
        #1;
        check("areset_kill", 32'(kill_pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0000_0002, 1'b1, 6'b0, 2'b0);
        step();
        check("post_areset_pass", out_data, 32'h0000_0002);

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        check("perf_reset_bubble", 32'(bubble_count), 32'd0);
        check("perf_reset_kill",   32'(kill_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(32'h0000_0003, 1'b1, 6'b000100, 2'b00);
            step();
        end
        check("perf_bubble_sat", 32'(bubble_count), 32'd15);
        check("perf_kill_zero",  32'(kill_count), 32'd0);
        drive(32'h0000_0004, 1'b1, 6'b000000, 2'b00);
        step();
        drive(32'h0000_0005, 1'b1, 6'b000000, 2'b01); // flush of a valid entry
        step();
        check("perf_kill_flush_valid", 32'(kill_count), 32'd1);
        drive(32'h0000_0006, 1'b1, 6'b000100, 2'b10); // flush of a bubble, arms kills
        step();
        check("perf_kill_flush_bubble", 32'(kill_count), 32'd1);
        drive(32'h0000_0007, 1'b1, 6'b000000, 2'b00); // deferred kill
        step();
        check("perf_kill_deferred", 32'(kill_count), 32'd2);
        check("perf_bubble_held",   32'(bubble_count), 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
